// File: rtl/uart_prog_loader.sv
// UART program loader: receives 8N1 bytes, packs them into 32-bit words,
// writes them to instruction/data memory and acknowledges completion.
//
// Ports:
//   sys_clk      single clock, all state on the rising edge
//   sys_rst_n    asynchronous active-low reset
//   upg_rx_i     UART serial in (8N1, idle high)
//   upg_clk_o    memory write clock (= sys_clk)
//   upg_wen_o    one-cycle word write strobe
//   upg_adr_o    word address, bit 14 selects data memory
//   upg_dat_o    assembled little-endian word
//   upg_done_o   sticky download-complete flag
//   upg_tx_o     UART serial out, sends ACK_BYTE once on completion
//   frame_err_o  sticky framing-error flag
module uart_prog_loader #(
  parameter int          CLKS_PER_BIT = 87,
  parameter int          IDLE_TIMEOUT = 1000000,
  parameter logic [7:0]  ACK_BYTE     = 8'h4B,
  parameter logic [14:0] ADR_INIT     = 15'h0000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        upg_rx_i,
  output logic        upg_clk_o,
  output logic        upg_wen_o,
  output logic [14:0] upg_adr_o,
  output logic [31:0] upg_dat_o,
  output logic        upg_done_o,
  output logic        upg_tx_o,
  output logic        frame_err_o
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [CW-1:0] FULL_M1 =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 =
    CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] TMO =
    IW'(IDLE_TIMEOUT);
  localparam logic [14:0] ADR_LAST = 15'h7FFF;

  typedef enum logic [2:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP,
    R_DONE
  } rx_state_t;

  typedef enum logic [2:0] {
    T_IDLE,
    T_START,
    T_DATA,
    T_STOP,
    T_HALT
  } tx_state_t;

  rx_state_t rx_st, rx_nxt;
  tx_state_t tx_st, tx_nxt;

  logic          rx_s1, rx_s2, rx_prev;
  logic          rx_fall;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [1:0]    lane;
  logic [23:0]   wbuf;
  logic [14:0]   adr_cnt;
  logic          wrote;
  logic [IW-1:0] idle_cnt;

  logic rx_half, rx_full, timeout;
  logic rx_cnt_clr, bit_smp;
  logic byte_ok, byte_bad, word_ok;

  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_idx, idx_nxt;
  logic          tx_full, tx_run, tx_bit;

  assign upg_clk_o = sys_clk;

  assign rx_fall = rx_prev & ~rx_s2;
  assign rx_half = (rx_cnt == HALF_M1);
  assign rx_full = (rx_cnt == FULL_M1);
  assign timeout = (idle_cnt == TMO);
  assign word_ok = byte_ok & (lane == 2'd3);

  // RX state register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) rx_st <= R_IDLE;
    else            rx_st <= rx_nxt;
  end

  // RX next state and per-cycle controls
  always_comb begin
    rx_nxt     = rx_st;
    rx_cnt_clr = 1'b1;
    bit_smp    = 1'b0;
    byte_ok    = 1'b0;
    byte_bad   = 1'b0;
    unique case (rx_st)
      R_IDLE: begin
        if (timeout && wrote)
          rx_nxt = R_DONE;
        else if (rx_fall)
          rx_nxt = R_START;
      end
      R_START: begin
        rx_cnt_clr = rx_half;
        // high at mid start bit is a glitch
        if (rx_half)
          rx_nxt = rx_s2 ? R_IDLE : R_DATA;
      end
      R_DATA: begin
        rx_cnt_clr = rx_full;
        bit_smp    = rx_full;
        if (rx_full && bit_idx == 3'd7)
          rx_nxt = R_STOP;
      end
      R_STOP: begin
        rx_cnt_clr = rx_full;
        if (rx_full) begin
          byte_ok  = rx_s2;
          byte_bad = ~rx_s2;
          // last address ends the download
          if (rx_s2 && lane == 2'd3 &&
              adr_cnt == ADR_LAST)
            rx_nxt = R_DONE;
          else
            rx_nxt = R_IDLE;
        end
      end
      R_DONE: rx_nxt = R_DONE;
      default: rx_nxt = R_IDLE;
    endcase
  end

  // RX datapath
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      // sync chain resets low so a line that is
      // mid-byte at release never looks like a start
      rx_s1       <= 1'b0;
      rx_s2       <= 1'b0;
      rx_prev     <= 1'b0;
      rx_cnt      <= '0;
      bit_idx     <= 3'd0;
      shreg       <= 8'd0;
      lane        <= 2'd0;
      wbuf        <= 24'd0;
      adr_cnt     <= ADR_INIT;
      wrote       <= 1'b0;
      idle_cnt    <= '0;
      upg_wen_o   <= 1'b0;
      upg_adr_o   <= 15'd0;
      upg_dat_o   <= 32'd0;
      upg_done_o  <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      rx_s1   <= upg_rx_i;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;

      rx_cnt <= rx_cnt_clr ? '0 : rx_cnt + CW'(1);

      if (bit_smp) begin
        shreg   <= {rx_s2, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end

      if (byte_bad)
        frame_err_o <= 1'b1;

      if (byte_ok) begin
        lane <= lane + 2'd1;
        case (lane)
          2'd0:    wbuf[7:0]   <= shreg;
          2'd1:    wbuf[15:8]  <= shreg;
          2'd2:    wbuf[23:16] <= shreg;
          default: wbuf        <= wbuf;
        endcase
      end

      upg_wen_o <= word_ok;
      if (word_ok) begin
        upg_dat_o <= {shreg, wbuf};
        upg_adr_o <= adr_cnt;
        wrote     <= 1'b1;
        if (adr_cnt != ADR_LAST)
          adr_cnt <= adr_cnt + 15'd1;
      end

      // saturates when nothing was written yet
      if (!rx_s2 || byte_ok)
        idle_cnt <= '0;
      else if (rx_st == R_IDLE && !timeout)
        idle_cnt <= idle_cnt + IW'(1);

      if (rx_st == R_DONE)
        upg_done_o <= 1'b1;
    end
  end

  // TX state register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) tx_st <= T_IDLE;
    else            tx_st <= tx_nxt;
  end

  assign tx_full = (tx_cnt == FULL_M1);
  assign tx_run  = (tx_st == T_START) ||
                   (tx_st == T_DATA)  ||
                   (tx_st == T_STOP);

  // TX next state and next line level
  always_comb begin
    tx_nxt  = tx_st;
    idx_nxt = tx_idx;
    unique case (tx_st)
      T_IDLE: begin
        // leaves IDLE on the edge done rises
        if (rx_st == R_DONE)
          tx_nxt = T_START;
      end
      T_START: begin
        if (tx_full)
          tx_nxt = T_DATA;
      end
      T_DATA: begin
        if (tx_full) begin
          idx_nxt = tx_idx + 3'd1;
          if (tx_idx == 3'd7)
            tx_nxt = T_STOP;
        end
      end
      T_STOP: begin
        if (tx_full)
          tx_nxt = T_HALT;
      end
      T_HALT: tx_nxt = T_HALT;
      default: tx_nxt = T_IDLE;
    endcase

    tx_bit = 1'b1;
    unique case (tx_nxt)
      T_START: tx_bit = 1'b0;
      T_DATA:  tx_bit = ACK_BYTE[idx_nxt];
      default: tx_bit = 1'b1;
    endcase
  end

  // TX datapath
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tx_cnt   <= '0;
      tx_idx   <= 3'd0;
      upg_tx_o <= 1'b1;
    end else begin
      if (!tx_run || tx_full)
        tx_cnt <= '0;
      else
        tx_cnt <= tx_cnt + CW'(1);
      tx_idx   <= idx_nxt;
      upg_tx_o <= tx_bit;
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: three instances with
// different start addresses, directed byte streams.
module tb_uart_prog_loader;

  localparam int CPB = 8;
  localparam int TMO = 300;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_bc;
  logic [2:0]  rx;
  logic [2:0]  uclk, wen, done, tx, ferr;
  logic [14:0] adr [3];
  logic [31:0] dat [3];

  logic [46:0] qa[$];
  logic [46:0] qb[$];
  logic [46:0] qc[$];

  int ncmp  = 0;
  int nfail = 0;

  uart_prog_loader #(
    .CLKS_PER_BIT(CPB),
    .IDLE_TIMEOUT(TMO),
    .ACK_BYTE(8'h4B),
    .ADR_INIT(15'h0000)
  ) dut_a (
    .sys_clk(clk), .sys_rst_n(rst_a),
    .upg_rx_i(rx[0]), .upg_clk_o(uclk[0]),
    .upg_wen_o(wen[0]), .upg_adr_o(adr[0]),
    .upg_dat_o(dat[0]), .upg_done_o(done[0]),
    .upg_tx_o(tx[0]), .frame_err_o(ferr[0])
  );

  uart_prog_loader #(
    .CLKS_PER_BIT(CPB),
    .IDLE_TIMEOUT(TMO),
    .ACK_BYTE(8'h4B),
    .ADR_INIT(15'h3FFF)
  ) dut_b (
    .sys_clk(clk), .sys_rst_n(rst_bc),
    .upg_rx_i(rx[1]), .upg_clk_o(uclk[1]),
    .upg_wen_o(wen[1]), .upg_adr_o(adr[1]),
    .upg_dat_o(dat[1]), .upg_done_o(done[1]),
    .upg_tx_o(tx[1]), .frame_err_o(ferr[1])
  );

  uart_prog_loader #(
    .CLKS_PER_BIT(CPB),
    .IDLE_TIMEOUT(TMO),
    .ACK_BYTE(8'h4B),
    .ADR_INIT(15'h7FFF)
  ) dut_c (
    .sys_clk(clk), .sys_rst_n(rst_bc),
    .upg_rx_i(rx[2]), .upg_clk_o(uclk[2]),
    .upg_wen_o(wen[2]), .upg_adr_o(adr[2]),
    .upg_dat_o(dat[2]), .upg_done_o(done[2]),
    .upg_tx_o(tx[2]), .frame_err_o(ferr[2])
  );

  task automatic cmp(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic unexp(input string nm,
                       input logic [14:0] a,
                       input logic [31:0] d);
    ncmp++;
    nfail++;
    $display("FAIL %s: strobe adr=%h dat=%h, none expected",
             nm, a, d);
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    logic [46:0] e;
    if (wen[0]) begin
      if (qa.size() == 0)
        unexp("strobe_a", adr[0], dat[0]);
      else begin
        e = qa.pop_front();
        cmp("strobe_a", {17'd0, adr[0], dat[0]},
            {17'd0, e});
      end
    end
    if (wen[1]) begin
      if (qb.size() == 0)
        unexp("strobe_b", adr[1], dat[1]);
      else begin
        e = qb.pop_front();
        cmp("strobe_b", {17'd0, adr[1], dat[1]},
            {17'd0, e});
      end
    end
    if (wen[2]) begin
      if (qc.size() == 0)
        unexp("strobe_c", adr[2], dat[2]);
      else begin
        e = qc.pop_front();
        cmp("strobe_c", {17'd0, adr[2], dat[2]},
            {17'd0, e});
      end
    end
  end

  // idle gap, start, 8 data LSB first, stop
  task automatic send(input int s,
                      input logic [7:0] b,
                      input logic stop);
    rx[s] = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    rx[s] = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx[s] = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx[s] = stop;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_word(input int s,
                           input logic [31:0] w);
    for (int i = 0; i < 4; i++)
      send(s, w[8*i +: 8], 1'b1);
  endtask

  task automatic wait_done(input int s,
                           input int lim,
                           input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(negedge clk);
      seen = done[s];
    end
    cmp(nm, 64'(done[s]), 64'd1);
  endtask

  // called at the first negedge with done high
  task automatic chk_ack(input int s,
                         input string nm);
    logic [7:0] b;
    cmp({nm, "_tx_edge"}, 64'(tx[s]), 64'd0);
    repeat (CPB / 2) @(negedge clk);
    cmp({nm, "_tx_start"}, 64'(tx[s]), 64'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = tx[s];
    end
    cmp({nm, "_tx_byte"}, 64'(b), 64'h4B);
    repeat (CPB) @(negedge clk);
    cmp({nm, "_tx_stop"}, 64'(tx[s]), 64'd1);
    repeat (3 * CPB) @(negedge clk);
    cmp({nm, "_tx_idle"}, 64'(tx[s]), 64'd1);
  endtask

  initial begin
    rst_a  = 1'b0;
    rst_bc = 1'b0;
    rx     = 3'b111;
    repeat (3) @(negedge clk);

    cmp("rst_wen",  64'(wen[0]),  64'd0);
    cmp("rst_adr",  64'(adr[0]),  64'd0);
    cmp("rst_dat",  64'(dat[0]),  64'd0);
    cmp("rst_done", 64'(done[0]), 64'd0);
    cmp("rst_tx",   64'(tx[0]),   64'd1);
    cmp("rst_ferr", 64'(ferr[0]), 64'd0);
    cmp("rst_adr_b", 64'(adr[1]), 64'd0);

    rst_a  = 1'b1;
    rst_bc = 1'b1;
    repeat (4) @(negedge clk);

    // first word at address 0
    qa.push_back({15'd0, 32'h12345678});
    send_word(0, 32'h12345678);
    cmp("ferr_clean", 64'(ferr[0]), 64'd0);

    // bad stop bit between valid bytes
    qa.push_back({15'd1, 32'hDDCCBBAA});
    send(0, 8'hAA, 1'b1);
    send(0, 8'h55, 1'b0);
    cmp("ferr_set", 64'(ferr[0]), 64'd1);
    send(0, 8'hBB, 1'b1);
    send(0, 8'hCC, 1'b1);
    send(0, 8'hDD, 1'b1);

    // one more word plus a stray byte, then idle
    qa.push_back({15'd2, 32'h04030201});
    send_word(0, 32'h04030201);
    send(0, 8'hEE, 1'b1);
    cmp("done_early", 64'(done[0]), 64'd0);
    wait_done(0, 3 * TMO, "done_timeout_a");
    chk_ack(0, "ack_a");
    cmp("ferr_sticky", 64'(ferr[0]), 64'd1);

    // rx ignored once done
    send(0, 8'h11, 1'b1);
    cmp("done_sticky", 64'(done[0]), 64'd1);
    cmp("tx_held", 64'(tx[0]), 64'd1);

    // reset in the middle of a byte
    fork
      send(0, 8'h22, 1'b1);
      begin
        repeat (4 * CPB) @(negedge clk);
        rst_a = 1'b0;
        #1;
        cmp("mid_rst_done", 64'(done[0]), 64'd0);
        cmp("mid_rst_ferr", 64'(ferr[0]), 64'd0);
        cmp("mid_rst_adr",  64'(adr[0]),  64'd0);
        cmp("mid_rst_dat",  64'(dat[0]),  64'd0);
        cmp("mid_rst_wen",  64'(wen[0]),  64'd0);
        cmp("mid_rst_tx",   64'(tx[0]),   64'd1);
      end
    join
    rst_a = 1'b1;

    // timeout with zero words must not finish
    repeat (TMO + 50) @(negedge clk);
    cmp("done_zero_words", 64'(done[0]), 64'd0);

    qa.push_back({15'd0, 32'hD4C3B2A1});
    send_word(0, 32'hD4C3B2A1);
    cmp("done_after_rst_word", 64'(done[0]), 64'd0);

    // crossing into data memory
    qb.push_back({15'h3FFF, 32'h11223344});
    qb.push_back({15'h4000, 32'h55667788});
    send_word(1, 32'h11223344);
    send_word(1, 32'h55667788);

    // last address ends the download directly
    qc.push_back({15'h7FFF, 32'hCAFEF00D});
    send(2, 8'h0D, 1'b1);
    send(2, 8'hF0, 1'b1);
    send(2, 8'hFE, 1'b1);
    cmp("done_c_pre", 64'(done[2]), 64'd0);
    fork
      send(2, 8'hCA, 1'b1);
      begin
        wait_done(2, 20 * CPB, "done_last_adr");
        chk_ack(2, "ack_c");
      end
    join

    repeat (10) @(negedge clk);
    cmp("qa_empty", 64'(qa.size()), 64'd0);
    cmp("qb_empty", 64'(qb.size()), 64'd0);
    cmp("qc_empty", 64'(qc.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
